lsu_ctrl: RTL and testbench

//  Load/store controller between EXU and the data-memory bus. Accepts one

---
 rtl/lsu_ctrl_pkg.sv | 50 +++++
 rtl/lsu_load_align.sv | 27 ++
 rtl/lsu_ctrl.sv | 165 ++++++++++++++++
 tb/tb_lsu_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_ctrl_pkg.sv
// Shared definitions for the load/store controller: funct3 encodings, FSM states
// and small decode helpers used by lsu_ctrl and lsu_load_align.
package lsu_defs;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } lsu_state_e;

  function automatic logic func3_bad(input logic wen, input logic [2:0] f3);
    logic bad;
    if (wen) begin
      bad = (f3 > F3_W);
    end else begin
      bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    end
    return bad;
  endfunction

  // Shifted strobes keep only the bytes that land inside the word.
  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] strb;
    case (f3)
      F3_B:    strb = 4'b0001 << off;
      F3_H:    strb = 4'b0011 << off;
      F3_W:    strb = 4'b1111;
      default: strb = 4'b0000;
    endcase
    return strb;
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic mis;
    case (f3)
      F3_H, F3_HU: mis = off[0];
      F3_W:        mis = (off != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load-data alignment: shifts the raw bus word by the byte
// offset and sign/zero-extends according to funct3.
module lsu_load_align
  import lsu_defs::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  off,
  input  logic [2:0]  func3,
  output logic [31:0] data
);

  logic [31:0] w_s;

  // Extract and extend the addressed bytes.
  always_comb begin
    w_s = raw >> {off, 3'b000};
    case (func3)
      F3_B:    data = {{24{w_s[7]}}, w_s[7:0]};
      F3_H:    data = {{16{w_s[15]}}, w_s[15:0]};
      F3_W:    data = w_s;
      F3_BU:   data = {24'h000000, w_s[7:0]};
      F3_HU:   data = {16'h0000, w_s[15:0]};
      default: data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller between EXU and the data-memory bus (one access in flight).
// Define LSU_MISALIGN_TRAP_EN to fault misaligned accesses without a bus request.
module lsu_ctrl
  import lsu_defs::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp_err,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  lsu_state_e       state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic             wen_r;
  logic [2:0]       func3_r;
  logic [1:0]       off_r;
  logic [31:0]      addr_r, wdata_r, rdata_r;
  logic [3:0]       wstrb_r;
  logic             err_r;
  logic [31:0]      load_data_s;
  logic             misalign_s, reject_s, timeout_s;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_s = misaligned(req_func3, req_addr[1:0]);
`else
  assign misalign_s = 1'b0;
`endif

  assign reject_s  = func3_bad(req_wen, req_func3) | misalign_s;
  assign timeout_s = (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

  lsu_load_align u_align (
    .raw   (mem_rdata),
    .off   (off_r),
    .func3 (func3_r),
    .data  (load_data_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and handshake decode; a response pulse beats a same-cycle timeout.
  always_comb begin
    state_nxt_s   = state_r;
    req_ready     = 1'b0;
    mem_req_valid = 1'b0;
    resp_valid    = 1'b0;
    case (state_r)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_nxt_s = reject_s ? S_RESP : S_REQ;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          state_nxt_s = S_WAIT;
        end else begin
          state_nxt_s = S_REQ;
        end
      end
      S_WAIT: begin
        if (mem_resp_valid || timeout_s) begin
          state_nxt_s = S_RESP;
        end else begin
          state_nxt_s = S_WAIT;
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_RESP;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Request latch, timeout counter and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r   <= '0;
      wen_r   <= 1'b0;
      func3_r <= 3'd0;
      off_r   <= 2'd0;
      addr_r  <= 32'h0000_0000;
      wdata_r <= 32'h0000_0000;
      wstrb_r <= 4'b0000;
      rdata_r <= 32'h0000_0000;
      err_r   <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (req_valid) begin
            wen_r   <= req_wen;
            func3_r <= req_func3;
            off_r   <= req_addr[1:0];
            addr_r  <= {req_addr[31:2], 2'b00};
            wdata_r <= req_wen ? (req_wdata << {req_addr[1:0], 3'b000}) : 32'h0000_0000;
            wstrb_r <= (req_wen && !reject_s) ? store_strb(req_func3, req_addr[1:0]) : 4'b0000;
            rdata_r <= 32'h0000_0000;
            err_r   <= reject_s;
            cnt_r   <= '0;
          end
        end
        S_REQ: begin
          cnt_r <= '0;
        end
        S_WAIT: begin
          if (mem_resp_valid) begin
            rdata_r <= (wen_r || mem_resp_err) ? 32'h0000_0000 : load_data_s;
            err_r   <= mem_resp_err;
          end else if (timeout_s) begin
            rdata_r <= 32'h0000_0000;
            err_r   <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign mem_req_wen = wen_r;
  assign mem_addr    = addr_r;
  assign mem_wdata   = wdata_r;
  assign mem_wstrb   = wstrb_r;
  assign resp_rdata  = rdata_r;
  assign resp_err    = err_r;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl; honours LSU_MISALIGN_TRAP_EN when defined.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wen;
  logic [2:0]  req_func3;
  logic [31:0] req_addr, req_wdata;
  logic        mem_req_valid, mem_req_ready, mem_req_wen;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_resp_valid, mem_resp_err;
  logic [31:0] mem_rdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lsu_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_wen(mem_req_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .mem_resp_err(mem_resp_err),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Runs one access with an always-ready bus; the response is driven resp_delay
  // cycles into WAIT (negative: never). o_cyc counts edges from acceptance.
  task automatic do_access(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata, input logic merr,
                           input int resp_delay, output logic [31:0] o_rdata, output logic o_err,
                           output int o_cyc, output logic [31:0] o_addr, output logic [31:0] o_wdata,
                           output logic [3:0] o_strb, output logic o_saw);
    int n, wc;
    logic in_wait, done;
    n = 0; wc = 0; in_wait = 1'b0; done = 1'b0;
    o_rdata = 32'hx; o_err = 1'bx; o_cyc = -1; o_addr = 32'h0; o_wdata = 32'h0;
    o_strb = 4'h0; o_saw = 1'b0;
    req_valid = 1'b1; req_wen = wen; req_func3 = f3; req_addr = addr; req_wdata = wdata;
    mem_req_ready = 1'b1; resp_ready = 1'b1; mem_rdata = rdata; mem_resp_err = merr;
    step;
    req_valid = 1'b0;
    n = 1;
    while (!done && n < 400) begin
      mem_resp_valid = 1'b0;
      if (resp_valid) begin
        o_rdata = resp_rdata; o_err = resp_err; o_cyc = n; done = 1'b1;
      end else begin
        if (in_wait) begin
          if (wc == resp_delay) mem_resp_valid = 1'b1;
          wc++;
        end else if (mem_req_valid) begin
          o_saw = 1'b1; o_addr = mem_addr; o_wdata = mem_wdata; o_strb = mem_wstrb;
          in_wait = 1'b1; wc = 0;
        end
        step;
        n++;
      end
    end
    total++;
    if (!done) begin
      $display("FAIL access_timeout: no resp_valid within %0d cycles", n);
      bad++;
    end
    step;
    mem_req_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_valid = 1'b0; req_wen = 1'b0; req_func3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 32'h0; mem_resp_err = 1'b0;
    resp_ready = 1'b0;
    step; step;
    rst = 1'b0;
    total++; if (req_ready !== 1'b1) begin $display("FAIL rst_req_ready: got %b want 1", req_ready); bad++; end
    total++; if (mem_req_valid !== 1'b0) begin $display("FAIL rst_mem_req_valid: got %b want 0", mem_req_valid); bad++; end
    total++; if (resp_valid !== 1'b0) begin $display("FAIL rst_resp_valid: got %b want 0", resp_valid); bad++; end
    total++; if (mem_wstrb !== 4'h0) begin $display("FAIL rst_wstrb: got %h want 0", mem_wstrb); bad++; end
    total++; if (resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
      $display("FAIL rst_resp: got rdata=%h err=%b want 0/0", resp_rdata, resp_err); bad++; end
    total++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_req_wen !== 1'b0) begin
      $display("FAIL rst_fields: got addr=%h wdata=%h wen=%b want 0", mem_addr, mem_wdata, mem_req_wen); bad++; end
  endtask

  task automatic test_loads;
    logic [31:0] rd, ad, wd; logic er, saw; logic [3:0] sb; int cyc;
    do_access(1'b0, 3'd0, 32'h8000_0003, 32'h0, 32'h80FF_1234, 1'b0, 0, rd, er, cyc, ad, wd, sb, saw);
    total++; if (rd !== 32'hFFFF_FF80 || er !== 1'b0) begin $display("FAIL lb_data: got %h/%b want ffffff80/0", rd, er); bad++; end
    total++; if (cyc !== 3) begin $display("FAIL lb_latency: got %0d want 3", cyc); bad++; end
    total++; if (ad !== 32'h8000_0000 || sb !== 4'h0 || saw !== 1'b1) begin
      $display("FAIL lb_bus: got addr=%h strb=%h saw=%b want 80000000/0/1", ad, sb, saw); bad++; end
    do_access(1'b0, 3'd5, 32'h0000_0002, 32'h0, 32'h80FF_1234, 1'b0, 0, rd, er, cyc, ad, wd, sb, saw);
    total++; if (rd !== 32'h0000_80FF) begin $display("FAIL lhu_data: got %h want 000080ff", rd); bad++; end
    do_access(1'b0, 3'd1, 32'h0000_0000, 32'h0, 32'h1234_8001, 1'b0, 0, rd, er, cyc, ad, wd, sb, saw);
    total++; if (rd !== 32'hFFFF_8001) begin $display("FAIL lh_data: got %h want ffff8001", rd); bad++; end
    do_access(1'b0, 3'd4, 32'h0000_0001, 32'h0, 32'h80FF_1234, 1'b0, 0, rd, er, cyc, ad, wd, sb, saw);
    total++; if (rd !== 32'h0000_0012) begin $display("FAIL lbu_data: got %h want 00000012", rd); bad++; end
    do_access(1'b0, 3'd2, 32'h0000_0008, 32'h0, 32'h5566_7788, 1'b1, 0, rd, er, cyc, ad, wd, sb, saw);
    total++; if (rd !== 32'h0 || er !== 1'b1) begin $display("FAIL lw_buserr: got %h/%b want 0/1", rd, er); bad++; end
    do_access(1'b0, 3'd3, 32'h0000_0000, 32'h0, 32'h1111_1111, 1'b0, 0, rd, er, cyc, ad, wd, sb, saw);
    total++; if (er !== 1'b1 || saw !== 1'b0 || cyc !== 1 || rd !== 32'h0) begin
      $display("FAIL bad_f3_load: got err=%b saw=%b cyc=%0d rd=%h want 1/0/1/0", er, saw, cyc, rd); bad++; end
  endtask

  task automatic test_stores;
    logic [31:0] rd, ad, wd; logic er, saw; logic [3:0] sb; int cyc;
    do_access(1'b1, 3'd1, 32'h8000_0002, 32'h0000_ABCD, 32'h0, 1'b0, 0, rd, er, cyc, ad, wd, sb, saw);
    total++; if (ad !== 32'h8000_0000 || sb !== 4'b1100 || wd !== 32'hABCD_0000) begin
      $display("FAIL sh_bus: got addr=%h strb=%b wdata=%h want 80000000/1100/abcd0000", ad, sb, wd); bad++; end
    total++; if (rd !== 32'h0 || er !== 1'b0) begin $display("FAIL sh_resp: got %h/%b want 0/0", rd, er); bad++; end
    do_access(1'b1, 3'd0, 32'h0000_0001, 32'h1234_56AB, 32'hFFFF_FFFF, 1'b0, 0, rd, er, cyc, ad, wd, sb, saw);
    total++; if (sb !== 4'b0010 || wd !== 32'h3456_AB00 || rd !== 32'h0) begin
      $display("FAIL sb_bus: got strb=%b wdata=%h rd=%h want 0010/3456ab00/0", sb, wd, rd); bad++; end
    do_access(1'b1, 3'd3, 32'h0000_0000, 32'h1, 32'h0, 1'b0, 0, rd, er, cyc, ad, wd, sb, saw);
    total++; if (er !== 1'b1 || saw !== 1'b0) begin $display("FAIL bad_f3_store: got err=%b saw=%b want 1/0", er, saw); bad++; end
  endtask

  task automatic test_stall;
    logic stable; int hs, vc;
    stable = 1'b1; hs = 0; vc = 0;
    req_valid = 1'b1; req_wen = 1'b1; req_func3 = 3'd2; req_addr = 32'h0000_0014; req_wdata = 32'h1122_3344;
    mem_req_ready = 1'b0; resp_ready = 1'b0;
    step;
    req_valid = 1'b0; req_wdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      if (mem_req_valid !== 1'b1 || mem_addr !== 32'h0000_0014 || mem_wdata !== 32'h1122_3344 ||
          mem_wstrb !== 4'hF || mem_req_wen !== 1'b1) stable = 1'b0;
      step;
    end
    mem_req_ready = 1'b1;
    if (mem_req_valid !== 1'b1) stable = 1'b0;
    step;
    mem_req_ready = 1'b0;
    if (mem_req_valid !== 1'b0) stable = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_err = 1'b0;
    step;
    mem_resp_valid = 1'b0;
    total++; if (stable !== 1'b1) begin $display("FAIL stall_req_stable: got %b want 1", stable); bad++; end
    for (int i = 0; i < 8; i++) begin
      resp_ready = (i >= 3) ? 1'b1 : 1'b0;
      if (resp_valid === 1'b1) begin
        vc++;
        if (resp_rdata !== 32'h0 || resp_err !== 1'b0) stable = 1'b0;
        if (resp_ready) hs++;
      end
      step;
    end
    resp_ready = 1'b0;
    total++; if (vc !== 4 || hs !== 1) begin $display("FAIL stall_resp_hold: got valid=%0d hs=%0d want 4/1", vc, hs); bad++; end
    total++; if (stable !== 1'b1 || req_ready !== 1'b1) begin
      $display("FAIL stall_resp_stable: got stable=%b ready=%b want 1/1", stable, req_ready); bad++; end
  endtask

  task automatic test_timeout;
    logic [31:0] rd, ad, wd; logic er, saw, quiet; logic [3:0] sb; int cyc;
    do_access(1'b0, 3'd2, 32'h0000_0020, 32'h0, 32'hDEAD_BEEF, 1'b0, -1, rd, er, cyc, ad, wd, sb, saw);
    total++; if (er !== 1'b1 || rd !== 32'h0 || cyc !== 258) begin
      $display("FAIL timeout: got err=%b rd=%h cyc=%0d want 1/0/258", er, rd, cyc); bad++; end
    quiet = 1'b1;
    mem_resp_valid = 1'b1;
    step;
    mem_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) quiet = 1'b0;
      step;
    end
    total++; if (quiet !== 1'b1) begin $display("FAIL late_resp_ignored: got %b want 1", quiet); bad++; end
    do_access(1'b0, 3'd2, 32'h0000_0024, 32'h0, 32'hCAFE_F00D, 1'b0, 255, rd, er, cyc, ad, wd, sb, saw);
    total++; if (er !== 1'b0 || rd !== 32'hCAFE_F00D || cyc !== 258) begin
      $display("FAIL resp_beats_timeout: got err=%b rd=%h cyc=%0d want 0/cafef00d/258", er, rd, cyc); bad++; end
  endtask

  task automatic test_misalign;
    logic [31:0] rd, ad, wd; logic er, saw; logic [3:0] sb; int cyc;
    do_access(1'b0, 3'd2, 32'h8000_0002, 32'h0, 32'h80FF_1234, 1'b0, 0, rd, er, cyc, ad, wd, sb, saw);
`ifdef LSU_MISALIGN_TRAP_EN
    total++; if (er !== 1'b1 || saw !== 1'b0 || rd !== 32'h0) begin
      $display("FAIL misalign_trap: got err=%b saw=%b rd=%h want 1/0/0", er, saw, rd); bad++; end
`else
    total++; if (er !== 1'b0 || saw !== 1'b1 || rd !== 32'h0000_80FF) begin
      $display("FAIL misalign_shift: got err=%b saw=%b rd=%h want 0/1/000080ff", er, saw, rd); bad++; end
`endif
  endtask

  task automatic test_rst_wait;
    logic quiet;
    quiet = 1'b1;
    req_valid = 1'b1; req_wen = 1'b0; req_func3 = 3'd2; req_addr = 32'h0000_0040;
    mem_req_ready = 1'b1; resp_ready = 1'b1;
    step;
    req_valid = 1'b0;
    step;
    mem_req_ready = 1'b0;
    rst = 1'b1;
    step;
    rst = 1'b0;
    total++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
      $display("FAIL rst_in_wait: got ready=%b rv=%b mrv=%b want 1/0/0", req_ready, resp_valid, mem_req_valid); bad++; end
    mem_resp_valid = 1'b1; mem_rdata = 32'h1234_5678;
    step;
    mem_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (resp_valid !== 1'b0) quiet = 1'b0;
      step;
    end
    total++; if (quiet !== 1'b1) begin $display("FAIL rst_no_result: got %b want 1", quiet); bad++; end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd, ad, wd; logic er, saw; logic [3:0] sb; int cyc;
    do_access(1'b1, 3'd2, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 1'b0, 0, rd, er, cyc, ad, wd, sb, saw);
    total++; if (sb !== 4'hF || wd !== 32'hDEAD_BEEF || ad !== 32'h0000_0100) begin
      $display("FAIL b2b_sw: got strb=%h wdata=%h addr=%h want f/deadbeef/100", sb, wd, ad); bad++; end
    do_access(1'b0, 3'd2, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, rd, er, cyc, ad, wd, sb, saw);
    total++; if (rd !== 32'hDEAD_BEEF || er !== 1'b0 || cyc !== 5) begin
      $display("FAIL b2b_lw: got rd=%h err=%b cyc=%0d want deadbeef/0/5", rd, er, cyc); bad++; end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_stall();
    test_timeout();
    test_misalign();
    test_rst_wait();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
